// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx
// Function : Framed parallel-to-serial transmitter (start, WIDTH bits LSB-first, stop).
// Revision : 1.0
// ============================================================================
module serial_frame_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(WIDTH - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             w_bit_end;

    assign w_bit_end = (cnt_q == c_cnt_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_idle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = w_bit_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        case (state_q)
            c_idle: begin
                cnt_d = '0;
                if (load) begin
                    shreg_d = din;
                    idx_d   = '0;
                    state_d = c_start;
                end
            end
            c_start: begin
                if (w_bit_end) begin
                    state_d = c_data;
                end
            end
            c_data: begin
                // The bit on the line is always shreg_q[0]; shift at each bit boundary.
                if (w_bit_end) begin
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == c_idx_last) begin
                        idx_d   = '0;
                        state_d = c_stop;
                    end
                end
            end
            c_stop: begin
                if (w_bit_end) begin
                    state_d = c_idle;
                end
            end
            default: begin
                state_d = c_idle;
            end
        endcase
    end

    always_comb begin
        tx_d    = 1'b1;
        busy_d  = (state_d != c_idle);
        ready_d = (state_d == c_idle);
        done_d  = (state_q == c_stop) && w_bit_end;
        case (state_d)
            c_start: tx_d = 1'b0;
            c_data:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx    = tx_q;
    assign busy  = busy_q;
    assign ready = ready_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_tx
// Function : Directed self-checking bench for serial_frame_tx (default and 4/1 corner).
// Revision : 1.0
// ============================================================================
module tb_serial_frame_tx;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] din;
    logic       ready, tx, busy, done;
    logic       load2;
    logic [3:0] din2;
    logic       ready2, tx2, busy2, done2;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) u_dut (
        .clk(clk), .rst(rst), .load(load), .din(din),
        .ready(ready), .tx(tx), .busy(busy), .done(done)
    );

    serial_frame_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) u_dut_small (
        .clk(clk), .rst(rst), .load(load2), .din(din2),
        .ready(ready2), .tx(tx2), .busy(busy2), .done(done2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; load = 1'b0; din = 8'h00; load2 = 1'b0; din2 = 4'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({tx, ready, busy, done, tx2, ready2, busy2, done2} !== 8'b1100_1100) begin
                errors++;
                $display("FAIL reset_hold i=%0d got tx/rdy/busy/done=%b%b%b%b small=%b%b%b%b want 1100",
                         i, tx, ready, busy, done, tx2, ready2, busy2, done2);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({tx, ready, busy, done, tx2, ready2, busy2, done2} !== 8'b1100_1100) begin
                errors++;
                $display("FAIL reset_release i=%0d got %b%b%b%b small=%b%b%b%b want 1100",
                         i, tx, ready, busy, done, tx2, ready2, busy2, done2);
            end
        end
    endtask

    task automatic test_single;
        logic [9:0] f;
        f = {1'b1, 8'hA5, 1'b0};
        din = 8'hA5; load = 1'b1;
        tick();
        load = 1'b0; din = 8'h00;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready_low got %b want 0", ready);
        end
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (tx !== f[c/N] || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL single_bit c=%0d got tx=%b busy=%b done=%b want tx=%b busy=1 done=0",
                         c, tx, busy, done, f[c/N]);
            end
            tick();
        end
        checks++;
        if ({done, ready, busy, tx} !== 4'b1101) begin
            errors++;
            $display("FAIL single_done got done/rdy/busy/tx=%b%b%b%b want 1101", done, ready, busy, tx);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_clear got %b want 0", done);
        end
    endtask

    task automatic test_ignored_load;
        logic [9:0] f;
        int dones;
        f = {1'b1, 8'h3C, 1'b0};
        dones = 0;
        din = 8'h3C; load = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (tx !== f[c/N] || done !== 1'b0 || ready !== 1'b0) begin
                errors++;
                $display("FAIL ignored_bit c=%0d got tx=%b done=%b ready=%b want tx=%b done=0 ready=0",
                         c, tx, done, ready, f[c/N]);
            end
            load = (c == 10);
            din  = (c == 10) ? 8'hFF : 8'h3C;
            tick();
        end
        load = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL ignored_done got %b want 1", done);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0 || tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_no_requeue got extra_dones=%0d tx=%b busy=%b want 0 1 0", dones, tx, busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] f1, f2;
        f1 = {1'b1, 8'h01, 1'b0};
        f2 = {1'b1, 8'h80, 1'b0};
        din = 8'h01; load = 1'b1;
        tick();
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (tx !== f1[c/N]) begin
                errors++;
                $display("FAIL b2b_first c=%0d got tx=%b want %b", c, tx, f1[c/N]);
            end
            if (c == 5) din = 8'h80;
            tick();
        end
        checks++;
        if ({done, ready, tx} !== 3'b111) begin
            errors++;
            $display("FAIL b2b_first_done got done/rdy/tx=%b%b%b want 111", done, ready, tx);
        end
        tick();
        load = 1'b0;
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (tx !== f2[c/N] || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL b2b_second c=%0d got tx=%b busy=%b done=%b want tx=%b busy=1 done=0",
                         c, tx, busy, done, f2[c/N]);
            end
            tick();
        end
        checks++;
        if ({done, ready, busy} !== 3'b110) begin
            errors++;
            $display("FAIL b2b_second_done got done/rdy/busy=%b%b%b want 110", done, ready, busy);
        end
        tick();
    endtask

    task automatic test_reset_mid_frame;
        logic [9:0] f, g;
        int dones;
        f = {1'b1, 8'hF0, 1'b0};
        g = {1'b1, 8'h0F, 1'b0};
        dones = 0;
        din = 8'hF0; load = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 0; c < 18; c++) begin
            checks++;
            if (tx !== f[c/N]) begin
                errors++;
                $display("FAIL midrst_pre c=%0d got tx=%b want %b", c, tx, f[c/N]);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({tx, busy, ready, done} !== 4'b1010) begin
            errors++;
            $display("FAIL midrst_abort got tx/busy/rdy/done=%b%b%b%b want 1010", tx, busy, ready, done);
        end
        for (int i = 0; i < 45; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL midrst_no_done got dones=%0d tx=%b want 0 1", dones, tx);
        end
        din = 8'h0F; load = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (tx !== g[c/N] || done !== 1'b0) begin
                errors++;
                $display("FAIL midrst_new c=%0d got tx=%b done=%b want tx=%b done=0", c, tx, done, g[c/N]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL midrst_new_done got %b want 1", done);
        end
        tick();
    endtask

    task automatic test_corner;
        logic [5:0] f;
        f = {1'b1, 4'b1001, 1'b0};
        din2 = 4'b1001; load2 = 1'b1;
        tick();
        load2 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (tx2 !== f[c] || busy2 !== 1'b1 || done2 !== 1'b0) begin
                errors++;
                $display("FAIL corner_bit c=%0d got tx=%b busy=%b done=%b want tx=%b busy=1 done=0",
                         c, tx2, busy2, done2, f[c]);
            end
            tick();
        end
        checks++;
        if ({done2, ready2, busy2} !== 3'b110) begin
            errors++;
            $display("FAIL corner_done got done/rdy/busy=%b%b%b want 110", done2, ready2, busy2);
        end
        tick();
        checks++;
        if (done2 !== 1'b0) begin
            errors++;
            $display("FAIL corner_done_clear got %b want 0", done2);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ignored_load();
        test_back_to_back();
        test_reset_mid_frame();
        test_corner();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-in, serial-out framed transmitter. Captures a WIDTH-bit word on a load handshake and shifts it onto a single line.
- Frame format: one start bit (0), WIDTH data bits LSB-first, one stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
- Drives the serial link consumed by the lab's flip-flop-based serial capture/shift-in logic. Same clk domain; no CDC inside.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- CLKS_PER_BIT, 4, clocks per serial bit (>=1); internal divider counter width is $clog2(CLKS_PER_BIT) (min 1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- load  input  1  request to transmit din; accepted only when ready=1.
- din  input  WIDTH  word to send; sampled on the accepting edge only.
- ready  output  1  1 = load will be accepted this cycle.
- tx  output  1  serial line; idle level 1.
- busy  output  1  1 while a frame is on the line (START/DATA/STOP).
- done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- All outputs are registered. Values on the first edge with rst=1: tx=1, ready=1, busy=0, done=0, state=IDLE, counters=0, shift register=0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0, ready=1.
  - On an edge with load=1: capture din into the shift register, clear the divider and bit index, go to START.
  - On that same edge: tx<=0, busy<=1, ready<=0.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with tx<=shreg[0].
- DATA:
  - Bit i (i=0..WIDTH-1) is held for CLKS_PER_BIT cycles.
  - At the end of each bit period, shift right and increment the index.
  - After bit WIDTH-1 completes, go to STOP with tx<=1.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE. On that edge: done<=1, busy<=0, ready<=1.
- done is high for exactly one cycle, the first IDLE cycle. It is cleared on the next edge unless another frame completes.
- Frame length:
  - (WIDTH+2)*CLKS_PER_BIT cycles from the first tx=0 cycle to the first done=1 cycle.
  - Default: 10*4 = 40 cycles.
- Back-to-back frames:
  - A load that is high during the done cycle is accepted, since ready=1.
  - The next start bit then begins the cycle after done, with no idle gap beyond the stop bit.
- A load while ready=0 is ignored; it is not queued. din changes during a frame have no effect.
- Holding load high continuously sends consecutive frames, each using the din present at its accept edge.
- Reset mid-frame:
  - Frame is aborted. Next edge: tx=1, busy=0, ready=1, done=0.
  - No done pulse is produced for the aborted frame.
- rst has priority over load on the same edge.
- CLKS_PER_BIT=1: one cycle per bit, same state sequence.
- Divider compares against CLKS_PER_BIT-1. No off-by-one is allowed: every bit's width is checked exactly.

Test Plan:
- Reset: clk period 20; rst=1 for 100 time units, load=0 -> tx=1, ready=1, busy=0, done=0 throughout and after release.
- Single frame: load=1 for one cycle with din=8'hA5, defaults -> line sequence 0, 1,0,1,0,0,1,0,1, 1, each bit exactly 4 cycles. busy=1 for 40 cycles. done pulses once, 40 cycles after tx first falls; ready returns to 1 with it.
- Ignored load: start 8'h3C; at cycle 10 of the frame pulse load with din=8'hFF -> transmitted bits stay 0,0,1,1,1,1,0,0 LSB-first; exactly one done pulse.
- Back-to-back: load held high with din=8'h01 then 8'h80 (switched during the first frame) -> second start bit begins the cycle after the first done. Frames decode as 8'h01 and 8'h80; stop bit is exactly 4 cycles.
- Reset mid-frame: start 8'hF0; assert rst during data bit 3 -> tx=1, busy=0, ready=1 on the next edge; no done pulse. A new load of 8'h0F afterward sends a correct full frame.
- Parameter corner: WIDTH=4, CLKS_PER_BIT=1, din=4'b1001 -> tx 0,1,0,0,1,1 on consecutive cycles; done 6 cycles after the start bit.
